// File: rtl/clk_gate_pkg.sv
// Shared encodings for the clock-gate enable controller.
package clk_gate_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } gate_state_e;

    localparam int GATE_CNT_W = 16;

endpackage

// File: rtl/clk_gate_ctrl_if.sv
// Activity / wake handshake bundle between the gated domain and clk_gate_ctrl.
interface clk_gate_ctrl_if
    import clk_gate_pkg::*;
();
    logic                  busy;
    logic                  wake_req;
    logic                  clk_en;
    logic                  wake_ack;
    logic                  gated;
    logic [GATE_CNT_W-1:0] gate_cnt;

    modport master (
        output busy, wake_req,
        input  clk_en, wake_ack, gated, gate_cnt
    );

    modport slave (
        input  busy, wake_req,
        output clk_en, wake_ack, gated, gate_cnt
    );
endinterface

// File: rtl/gate_down_cnt.sv
// Loadable down-counter shared by the idle and wake windows; parks at zero.
module gate_down_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             in_clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge in_clk) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/clk_gate_ctrl.sv
// Enable-side clock-gate controller: idle timeout, wake settle, four-phase ack.
// Optional gating-event counter built when CLK_GATE_STATS_EN is defined.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic           in_clk,
    input  logic           rst,
    clk_gate_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] IDLE_LOAD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);

    gate_state_e      state;
    logic             clk_en_q, wake_ack_q, gated_q;
    logic             activity;
    logic             cnt_load, cnt_dec, cnt_zero;
    logic [CNT_W-1:0] cnt_val;

    assign activity = bus.busy | bus.wake_req;

    // Counter control mirrors the state transitions below.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        unique case (state)
            ST_RUN: if (!activity) begin
                cnt_load = 1'b1;
                cnt_val  = IDLE_LOAD;
            end
            ST_IDLE: if (activity) cnt_load = 1'b1;
                     else          cnt_dec  = 1'b1;
            ST_GATED: if (activity) begin
                cnt_load = 1'b1;
                cnt_val  = WAKE_LOAD;
            end
            ST_WAKE: cnt_dec = 1'b1;
            default: ;
        endcase
    end

    gate_down_cnt #(.CNT_W(CNT_W)) u_cnt (
        .in_clk   (in_clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge in_clk) begin
        if (rst) begin
            state      <= ST_RUN;
            clk_en_q   <= 1'b1;
            wake_ack_q <= 1'b0;
            gated_q    <= 1'b0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    clk_en_q   <= 1'b1;
                    wake_ack_q <= bus.wake_req;
                    if (!activity) state <= ST_IDLE;
                end
                ST_IDLE: begin
                    wake_ack_q <= 1'b0;
                    // Activity on the terminal count wins over gating.
                    if (activity) begin
                        state <= ST_RUN;
                    end else if (cnt_zero) begin
                        state    <= ST_GATED;
                        clk_en_q <= 1'b0;
                        gated_q  <= 1'b1;
                    end
                end
                ST_GATED: if (activity) begin
                    state    <= ST_WAKE;
                    clk_en_q <= 1'b1;
                    gated_q  <= 1'b0;
                end
                ST_WAKE: begin
                    wake_ack_q <= 1'b0;
                    if (cnt_zero) state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    assign bus.clk_en   = clk_en_q;
    assign bus.wake_ack = wake_ack_q;
    assign bus.gated    = gated_q;

`ifdef CLK_GATE_STATS_EN
    logic [GATE_CNT_W-1:0] gate_cnt_q;
    logic                  gate_evt;

    assign gate_evt = (state == ST_IDLE) && !activity && cnt_zero;

    always_ff @(posedge in_clk) begin
        if (rst)
            gate_cnt_q <= '0;
        else if (gate_evt && gate_cnt_q != {GATE_CNT_W{1'b1}})
            gate_cnt_q <= gate_cnt_q + 1'b1;
    end

    assign bus.gate_cnt = gate_cnt_q;
`else
    assign bus.gate_cnt = '0;
`endif
endmodule
